// File: rtl/decode_queue.sv
// RV32I decode queue: decodes fetched instructions into control words and buffers them in a DEPTH-entry ring.
// Define M_EXT_DECODE_EN to accept the M-extension (funct7=0000001) register forms as legal.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32:0]     out_ctrl,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_illegal,
    output logic [CW-1:0]   occupancy
);

    // Control word layout, MSB first; out_ctrl carries exactly this packing.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [2:0] aluop;
        logic [2:0] cmpop;
        logic       alumux1;
        logic [2:0] alumux2;
        logic       cmpmux;
        logic [3:0] regfilemux;
        logic       load_regfile;
        logic       dcache_read;
        logic       dcache_write;
        logic       branch_enable;
        logic       jal_enable;
        logic       jalr_enable;
        logic       forward_cmp;
        logic       m_enable;
    } ctrl_t;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = $bits(ctrl_t) + 2 * XLEN + 16;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
    localparam logic [6:0] F7_ALT = 7'b0100000, F7_MUL = 7'b0000001;
    localparam logic [2:0] ALU_SRA = 3'b010, ALU_SUB = 3'b011, CMP_BLT = 3'b100, CMP_BLTU = 3'b110;
    localparam logic [2:0] MUX2_U = 3'd1, MUX2_B = 3'd2, MUX2_S = 3'd3, MUX2_J = 3'd4, MUX2_RS2 = 3'd5;
    localparam logic [3:0] RF_BREN = 4'd1, RF_UIMM = 4'd2, RF_LW = 4'd3, RF_PC4 = 4'd4;
    localparam logic [3:0] RF_LB = 4'd5, RF_LBU = 4'd6, RF_LH = 4'd7, RF_LHU = 4'd8;

    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic [31:0] w_i_imm, w_s_imm, w_b_imm, w_u_imm, w_j_imm, w_dec_imm, w_imm;
    logic [XLEN-1:0] w_imm_x;
    ctrl_t       w_dec, w_ctrl;
    logic        w_bad, w_push, w_pop;
    logic [EW-1:0] w_entry, w_head;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        ptr_next = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_opcode = in_instr[6:0];
    assign w_rd     = in_instr[11:7];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_i_imm  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_s_imm  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_b_imm  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_u_imm  = {in_instr[31:12], 12'h000};
    assign w_j_imm  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Raw opcode decode: control fields, selected immediate and legality.
    always_comb begin
        w_dec        = '0;
        w_dec.opcode = w_opcode;
        w_dec.funct3 = w_funct3;
        w_dec_imm    = 32'd0;
        w_bad        = 1'b0;
        case (w_opcode)
            OP_LUI: begin
                w_dec.load_regfile = 1'b1;
                w_dec.regfilemux   = RF_UIMM;
                w_dec_imm          = w_u_imm;
            end
            OP_AUIPC: begin
                w_dec.load_regfile = 1'b1;
                w_dec.alumux1      = 1'b1;
                w_dec.alumux2      = MUX2_U;
                w_dec_imm          = w_u_imm;
            end
            OP_JAL: begin
                w_dec.load_regfile = 1'b1;
                w_dec.regfilemux   = RF_PC4;
                w_dec.jal_enable   = 1'b1;
                w_dec.alumux1      = 1'b1;
                w_dec.alumux2      = MUX2_J;
                w_dec_imm          = w_j_imm;
            end
            OP_JALR: begin
                w_dec.load_regfile = 1'b1;
                w_dec.regfilemux   = RF_PC4;
                w_dec.jalr_enable  = 1'b1;
                w_dec_imm          = w_i_imm;
            end
            OP_BR: begin
                w_dec.cmpop         = w_funct3;
                w_dec.alumux1       = 1'b1;
                w_dec.alumux2       = MUX2_B;
                w_dec.branch_enable = 1'b1;
                w_dec_imm           = w_b_imm;
                w_bad               = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            OP_LOAD: begin
                w_dec.dcache_read  = 1'b1;
                w_dec.load_regfile = 1'b1;
                w_dec_imm          = w_i_imm;
                case (w_funct3)
                    3'b000:  w_dec.regfilemux = RF_LB;
                    3'b001:  w_dec.regfilemux = RF_LH;
                    3'b010:  w_dec.regfilemux = RF_LW;
                    3'b100:  w_dec.regfilemux = RF_LBU;
                    3'b101:  w_dec.regfilemux = RF_LHU;
                    default: w_bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                w_dec.dcache_write = 1'b1;
                w_dec.alumux2      = MUX2_S;
                w_dec_imm          = w_s_imm;
                w_bad              = (w_funct3 >= 3'b011);
            end
            OP_IMM: begin
                w_dec.load_regfile = 1'b1;
                w_dec.aluop        = w_funct3;
                w_dec_imm          = w_i_imm;
                case (w_funct3)
                    3'b010, 3'b011: begin
                        w_dec.cmpop       = w_funct3[0] ? CMP_BLTU : CMP_BLT;
                        w_dec.cmpmux      = 1'b1;
                        w_dec.regfilemux  = RF_BREN;
                        w_dec.forward_cmp = 1'b1;
                    end
                    3'b001:  w_bad = (w_funct7 != 7'd0);
                    3'b101: begin
                        if (w_funct7 == F7_ALT) begin
                            w_dec.aluop = ALU_SRA;
                        end else begin
                            w_bad = (w_funct7 != 7'd0);
                        end
                    end
                    default: w_bad = 1'b0;
                endcase
            end
            OP_REG: begin
                w_dec.load_regfile = 1'b1;
                w_dec.aluop        = w_funct3;
                w_dec.alumux2      = MUX2_RS2;
                case (w_funct7)
                    7'd0: begin
                        case (w_funct3)
                            3'b010, 3'b011: begin
                                w_dec.cmpop       = w_funct3[0] ? CMP_BLTU : CMP_BLT;
                                w_dec.regfilemux  = RF_BREN;
                                w_dec.forward_cmp = 1'b1;
                            end
                            default: w_dec.forward_cmp = 1'b0;
                        endcase
                    end
                    F7_ALT: begin
                        case (w_funct3)
                            3'b000:  w_dec.aluop = ALU_SUB;
                            3'b101:  w_dec.aluop = ALU_SRA;
                            default: w_bad = 1'b1;
                        endcase
                    end
                    F7_MUL: begin
`ifdef M_EXT_DECODE_EN
                        w_dec.m_enable = 1'b1;
`else
                        w_bad = 1'b1;
`endif
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            default: w_bad = 1'b1;
        endcase
    end

    // Illegal entries keep only opcode/funct3; writes to x0 never load the regfile.
    always_comb begin
        w_ctrl = w_dec;
        w_imm  = w_dec_imm;
        if (w_bad) begin
            w_ctrl        = '0;
            w_ctrl.opcode = w_opcode;
            w_ctrl.funct3 = w_funct3;
            w_imm         = 32'd0;
        end else if (w_rd == 5'd0) begin
            w_ctrl.load_regfile = 1'b0;
        end else begin
            w_ctrl.load_regfile = w_dec.load_regfile;
        end
    end

    assign w_imm_x   = XLEN'($signed(w_imm));
    assign w_entry   = {w_ctrl, w_imm_x, in_pc, w_rd, in_instr[19:15], in_instr[24:20], w_bad};
    assign in_ready  = rst & (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready;
    assign occupancy = r_count;
    assign w_head    = r_mem[r_head];

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= ptr_next(r_tail);
            if (w_pop)  r_head <= ptr_next(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= w_entry;
    end

    // Head entry drives the outputs, zeroed while the queue is empty.
    always_comb begin
        if (out_valid) begin
            {out_ctrl, out_imm, out_pc, out_rd, out_rs1, out_rs2, out_illegal} = w_head;
        end else begin
            {out_ctrl, out_imm, out_pc, out_rd, out_rs1, out_rs2, out_illegal} = '0;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios plus randomized traffic against a queue model.
module tb_decode_queue;
    localparam int XLEN = 32, DEPTH = 2, CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [2:0] aluop;
        logic [2:0] cmpop;
        logic       alumux1;
        logic [2:0] alumux2;
        logic       cmpmux;
        logic [3:0] regfilemux;
        logic       load_regfile;
        logic       dcache_read;
        logic       dcache_write;
        logic       branch_enable;
        logic       jal_enable;
        logic       jalr_enable;
        logic       forward_cmp;
        logic       m_enable;
    } ctrl_t;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr;
    logic [XLEN-1:0] in_pc, out_imm, out_pc;
    logic [32:0] out_ctrl;
    logic [4:0] out_rd, out_rs1, out_rs2;
    logic [CW-1:0] occupancy;
    ctrl_t oc;

    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    assign oc = out_ctrl;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_illegal(out_illegal), .occupancy(occupancy)
    );

    // Reference decoder written per mnemonic class.
    function automatic void ref_decode(input logic [31:0] ins, output ctrl_t c,
                                       output logic [31:0] imm, output logic ill);
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] iimm;
        f3 = ins[14:12];
        f7 = ins[31:25];
        iimm = {{20{ins[31]}}, ins[31:20]};
        c = '0; c.opcode = ins[6:0]; c.funct3 = f3; imm = 32'd0; ill = 1'b0;
        case (ins[6:0])
            7'h37: begin imm = {ins[31:12], 12'h000}; c.regfilemux = 4'd2; c.load_regfile = 1'b1; end
            7'h17: begin imm = {ins[31:12], 12'h000}; c.alumux1 = 1'b1; c.alumux2 = 3'd1; c.load_regfile = 1'b1; end
            7'h6F: begin
                imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                c.alumux1 = 1'b1; c.alumux2 = 3'd4; c.regfilemux = 4'd4; c.load_regfile = 1'b1; c.jal_enable = 1'b1;
            end
            7'h67: begin imm = iimm; c.regfilemux = 4'd4; c.load_regfile = 1'b1; c.jalr_enable = 1'b1; end
            7'h63: begin
                ill = (f3 == 3'd2) || (f3 == 3'd3);
                imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                c.cmpop = f3; c.alumux1 = 1'b1; c.alumux2 = 3'd2; c.branch_enable = 1'b1;
            end
            7'h03: begin
                ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
                imm = iimm; c.dcache_read = 1'b1; c.load_regfile = 1'b1;
                c.regfilemux = (f3 == 3'd0) ? 4'd5 : (f3 == 3'd1) ? 4'd7 : (f3 == 3'd2) ? 4'd3 :
                               (f3 == 3'd4) ? 4'd6 : 4'd8;
            end
            7'h23: begin
                ill = (f3 > 3'd2);
                imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                c.dcache_write = 1'b1; c.alumux2 = 3'd3;
            end
            7'h13: begin
                imm = iimm; c.load_regfile = 1'b1; c.aluop = f3;
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    c.cmpop = (f3 == 3'd2) ? 3'd4 : 3'd6; c.cmpmux = 1'b1; c.regfilemux = 4'd1; c.forward_cmp = 1'b1;
                end
                if (f3 == 3'd1 && f7 != 7'd0) ill = 1'b1;
                if (f3 == 3'd5 && f7 == 7'h20) c.aluop = 3'd2;
                if (f3 == 3'd5 && f7 != 7'h20 && f7 != 7'd0) ill = 1'b1;
            end
            7'h33: begin
                c.load_regfile = 1'b1; c.aluop = f3; c.alumux2 = 3'd5;
                if (f7 == 7'd0) begin
                    if (f3 == 3'd2 || f3 == 3'd3) begin
                        c.cmpop = (f3 == 3'd2) ? 3'd4 : 3'd6; c.regfilemux = 4'd1; c.forward_cmp = 1'b1;
                    end
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    c.aluop = 3'd3;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    c.aluop = 3'd2;
                end else if (f7 == 7'h01) begin
`ifdef M_EXT_DECODE_EN
                    c.m_enable = 1'b1;
`else
                    ill = 1'b1;
`endif
                end else begin
                    ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            c = '0; c.opcode = ins[6:0]; c.funct3 = f3; imm = 32'd0;
        end else if (ins[11:7] == 5'd0) begin
            c.load_regfile = 1'b0;
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r[6:0] = 7'h37;  1: r[6:0] = 7'h17;  2: r[6:0] = 7'h6F;
            3: r[6:0] = 7'h67;  4: r[6:0] = 7'h63;  5: r[6:0] = 7'h03;
            6: r[6:0] = 7'h23;  7: r[6:0] = 7'h13;  8: r[6:0] = 7'h33;
            default: r[6:0] = r[6:0];
        endcase
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: r[31:25] = r[31:25];
        endcase
        return r;
    endfunction

    // Clocks one edge and applies the queue rules to the model using the inputs currently driven.
    task automatic tick();
        logic exp_push, exp_pop;
        exp_push = rst && in_valid && !flush && (q_instr.size() < DEPTH);
        exp_pop  = out_ready && (q_instr.size() > 0);
        @(posedge clk);
        if (!rst || flush) begin
            q_instr.delete(); q_pc.delete();
        end else begin
            if (exp_pop) begin void'(q_instr.pop_front()); void'(q_pc.pop_front()); end
            if (exp_push) begin q_instr.push_back(in_instr); q_pc.push_back(in_pc); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h40; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
        if (in_ready !== 1'b0) errors++;
        tick(); tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== '0) begin errors++;
            $display("FAIL reset_state: valid=%b occ=%0d want 0/0", out_valid, occupancy); end
        checks++; if ({out_ctrl, out_imm, out_pc, out_rd, out_rs1, out_rs2, out_illegal} !== '0) begin errors++;
            $display("FAIL reset_outputs: ctrl=%h imm=%h pc=%h rd=%0d ill=%b want all 0", out_ctrl, out_imm, out_pc, out_rd, out_illegal); end
    endtask

    task automatic test_addi();
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h40; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || occupancy !== CW'(1)) begin errors++;
            $display("FAIL addi_valid: valid=%b occ=%0d want 1/1", out_valid, occupancy); end
        checks++; if (out_imm !== 32'd5 || out_rd !== 5'd1 || out_pc !== 32'h40) begin errors++;
            $display("FAIL addi_fields: imm=%h rd=%0d pc=%h want 5/1/40", out_imm, out_rd, out_pc); end
        checks++; if (oc.load_regfile !== 1'b1 || out_illegal !== 1'b0) begin errors++;
            $display("FAIL addi_ctrl: load_regfile=%b illegal=%b want 1/0", oc.load_regfile, out_illegal); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_pop: valid=%b want 0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00100113; in_pc = 32'h200; tick();
        in_instr = 32'h00208193; in_pc = 32'h204; tick();
        in_instr = 32'h00310213; in_pc = 32'h208;
        #1;
        checks++; if (in_ready !== 1'b0 || occupancy !== CW'(2)) begin errors++;
            $display("FAIL stall_full: in_ready=%b occ=%0d want 0/2", in_ready, occupancy); end
        tick();
        checks++; if (occupancy !== CW'(2) || out_pc !== 32'h200) begin errors++;
            $display("FAIL stall_hold: occ=%0d pc=%h want 2/200", occupancy, out_pc); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pushpop_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (occupancy !== CW'(1) || out_pc !== 32'h204 || out_rd !== 5'd3) begin errors++;
            $display("FAIL full_pushpop: occ=%0d pc=%h rd=%0d want 1/204/3", occupancy, out_pc, out_rd); end
        in_valid = 1'b0; tick();
        checks++; if (occupancy !== '0 || out_valid !== 1'b0) begin errors++;
            $display("FAIL stall_drain: occ=%0d valid=%b want 0/0", occupancy, out_valid); end
        in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'h00418293; in_pc = 32'h20C; tick();
        in_valid = 1'b0;
        checks++; if (out_pc !== 32'h20C || out_rd !== 5'd5) begin errors++;
            $display("FAIL tail_position: pc=%h rd=%0d want 20c/5", out_pc, out_rd); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_branch_store();
        ctrl_t e;
        in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'hFE000CE3; in_pc = 32'h100; tick();
        checks++; if (out_imm !== 32'hFFFFFFF8 || oc.branch_enable !== 1'b1 || oc.cmpop !== 3'b000) begin errors++;
            $display("FAIL beq: imm=%h br=%b cmpop=%b want fffffff8/1/000", out_imm, oc.branch_enable, oc.cmpop); end
        in_instr = 32'h0020B023; in_pc = 32'h104; out_ready = 1'b1; tick();
        in_valid = 1'b0;
        e = '0; e.opcode = 7'h23; e.funct3 = 3'b011;
        checks++; if (out_illegal !== 1'b1 || out_ctrl !== e || out_imm !== 32'd0) begin errors++;
            $display("FAIL sw_illegal: ill=%b ctrl=%h imm=%h want 1/%h/0", out_illegal, out_ctrl, out_imm, e); end
        tick(); out_ready = 1'b0;
    endtask

    task automatic test_flush();
        in_valid = 1'b1; out_ready = 1'b0;
        in_instr = 32'h00100113; in_pc = 32'h300; tick();
        in_instr = 32'h00200193; in_pc = 32'h304; tick();
        flush = 1'b1; out_ready = 1'b1; in_instr = 32'h7FF00513; in_pc = 32'hDEAD0; tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (occupancy !== '0 || out_valid !== 1'b0) begin errors++;
            $display("FAIL flush: occ=%0d valid=%b want 0/0", occupancy, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_pc !== '0) begin errors++;
            $display("FAIL flush_drop: valid=%b pc=%h want 0/0", out_valid, out_pc); end
        out_ready = 1'b0;
    endtask

    task automatic test_mul_x0();
        in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'h022081B3; in_pc = 32'h400; tick();
`ifdef M_EXT_DECODE_EN
        checks++; if (out_illegal !== 1'b0 || oc.m_enable !== 1'b1 || oc.load_regfile !== 1'b1) begin errors++;
            $display("FAIL mul: ill=%b m=%b ld=%b want 0/1/1", out_illegal, oc.m_enable, oc.load_regfile); end
`else
        checks++; if (out_illegal !== 1'b1 || oc.m_enable !== 1'b0) begin errors++;
            $display("FAIL mul: ill=%b m=%b want 1/0", out_illegal, oc.m_enable); end
`endif
        in_instr = 32'h00000013; in_pc = 32'h404; out_ready = 1'b1; tick();
        in_valid = 1'b0;
        checks++; if (oc.load_regfile !== 1'b0 || out_illegal !== 1'b0 || out_pc !== 32'h404) begin errors++;
            $display("FAIL nop_x0: ld=%b ill=%b pc=%h want 0/0/404", oc.load_regfile, out_illegal, out_pc); end
        tick(); out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_instr = 32'h00000093 | (32'(k) << 20); in_pc = 32'h500 + 32'(4 * k);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready); end
            tick();
            checks++; if (occupancy !== CW'(1) || out_pc !== 32'h500 + 32'(4 * k) || out_imm !== 32'(k)) begin errors++;
                $display("FAIL b2b[%0d]: occ=%0d pc=%h imm=%h want 1/%h/%h", k, occupancy, out_pc, out_imm, 32'h500 + 32'(4 * k), k); end
        end
        in_valid = 1'b0; tick(); out_ready = 1'b0;
    endtask

    task automatic test_random();
        ctrl_t ec;
        logic [31:0] ei;
        logic eil;
        for (int n = 0; n < 600; n++) begin
            checks++; if (out_valid !== (q_instr.size() != 0) || occupancy !== CW'(q_instr.size())) begin errors++;
                $display("FAIL rand_occ[%0d]: valid=%b occ=%0d want occ %0d", n, out_valid, occupancy, q_instr.size()); end
            if (q_instr.size() > 0) begin
                ref_decode(q_instr[0], ec, ei, eil);
                checks++; if (out_ctrl !== ec || out_imm !== ei || out_illegal !== eil) begin errors++;
                    $display("FAIL rand_decode[%0d]: instr=%h ctrl=%h imm=%h ill=%b want %h/%h/%b", n, q_instr[0], out_ctrl, out_imm, out_illegal, ec, ei, eil); end
                checks++; if (out_pc !== q_pc[0] || out_rd !== q_instr[0][11:7] || out_rs1 !== q_instr[0][19:15] || out_rs2 !== q_instr[0][24:20]) begin errors++;
                    $display("FAIL rand_fields[%0d]: pc=%h rd=%0d rs1=%0d rs2=%0d want pc %h instr %h", n, out_pc, out_rd, out_rs1, out_rs2, q_pc[0], q_instr[0]); end
            end else begin
                checks++; if (out_ctrl !== '0 || out_imm !== '0 || out_pc !== '0) begin errors++;
                    $display("FAIL rand_empty[%0d]: ctrl=%h imm=%h pc=%h want 0", n, out_ctrl, out_imm, out_pc); end
            end
            rst       = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom & 32'hFFFFFFFC;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++; if (in_ready !== (rst && q_instr.size() < DEPTH)) begin errors++;
                $display("FAIL rand_in_ready[%0d]: got %b rst=%b size=%0d", n, in_ready, rst, q_instr.size()); end
            tick();
        end
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_addi();
        test_stall();
        test_branch_store();
        test_flush();
        test_mul_x0();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised, buffered successor to the combinational control decoder. Accepts fetched RV32I instructions over a valid/ready handshake and decodes each one into an `rv32i_control` word. Each entry also carries the selected immediate, register indices and an illegal-instruction flag. Entries go into a DEPTH-entry circular queue that feeds the execute stage, decoupling fetch from execute stalls; flush support covers branch/jump redirects.

## Interface
- `XLEN`, 32: datapath and PC width.
- `DEPTH`, 2: queue entries; must be at least 1.
- `CW`, `$clog2(DEPTH+1)`: occupancy counter width (derived).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock; synchronous, active-low.
- `flush`  in  1  discard all queued entries and any same-cycle push.
- `in_valid`  in  1  `in_instr`/`in_pc` valid.
- `in_ready`  out  1  queue can accept this cycle.
- `in_instr`  in  32  raw instruction.
- `in_pc`  in  XLEN  instruction PC.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer takes head.
- `out_ctrl`  out  rv32i_control  decoded control word.
- `out_imm`  out  XLEN  sign-extended immediate selected by opcode.
- `out_pc`  out  XLEN  PC of head entry.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register indices.
- `out_illegal`  out  1  head instruction is illegal.
- `occupancy`  out  CW  number of valid entries.

## Operation
- Decoding is combinational on `in_instr`; the result is written at the tail on push (`in_valid & in_ready & ~flush`).
- Pop on `out_valid & out_ready`; head pointer advances with wrap at `DEPTH-1`.
- `in_ready = rst & (occupancy < DEPTH)`. It is independent of `out_ready`, so a full queue takes no push even when a pop occurs in the same cycle.
- Push and pop in the same cycle (not full): occupancy unchanged, both pointers advance.
- Control mapping:
  - Same encoding as the existing control word: opcode/funct3 pass-through and default muxes.
  - lui loads `u_imm`; auipc adds `pc+u_imm`; jal/jalr write `pc_plus4` and set `jal_enable`/`jalr_enable`.
  - Branches set `cmpop` from funct3, ALU `pc+b_imm`, and `branch_enable`.
  - Loads set `dcache_read`, ALU add `i_imm`, and the regfilemux lb/lh/lw/lbu/lhu by funct3.
  - Stores set `dcache_write`, ALU add `s_imm`.
  - slt/sltu (imm and reg forms) write `br_en` and set `forward_cmp`.
  - Shifts: funct7 bit 5 selects sra; add/sub uses the same bit.
- Immediate: lui/auipc→U, jal→J, br→B, store→S, load/imm/jalr→I, reg and illegal→0.
- rd==0: `load_regfile` is forced to 0.
- Illegal conditions:
  - unknown opcode;
  - load funct3 011/110/111;
  - store funct3 ≥011;
  - branch funct3 010/011;
  - slli funct7≠0;
  - srli/srai funct7 ∉ {0, 0100000};
  - reg funct7 ∉ {0, 0100000 (add/sr only)}, plus M per Configuration.
- Illegal entries: ctrl all-zero except opcode/funct3, `out_illegal=1`. They are delivered in order and are never dropped.
- `flush`: occupancy and pointers go to 0 next cycle; the push in the flush cycle is dropped; a pop in the flush cycle is allowed but irrelevant.

## Timing
- Reset (`rst=0` at a clock edge): occupancy 0, pointers 0, `out_valid=0`, and `out_ctrl`/`out_imm`/`out_pc`/`out_rd`/`out_rs1`/`out_rs2`/`out_illegal` all 0. `in_ready=0` while `rst=0`. Reset mid-stream discards all entries.
- Latency: push at edge N → `out_valid=1` with that entry after edge N; no bypass from input to output.
- Outputs come from the registered head entry; they are zero when empty.
- Sustained throughput is 1/cycle with `out_ready=1` and DEPTH≥2. With DEPTH=1 it is 1 per 2 cycles.
- Output fields hold stable while `out_valid & ~out_ready`.

## Configuration
- `M_EXT_DECODE_EN`, defined: op_reg with funct7=0000001 is legal for all funct3. It sets `m_enable=1`, regfilemux `alu_out`, `load_regfile=1` (rd≠0) and `forward_cmp=0`.
- Undefined: funct7=0000001 is illegal and `m_enable` is always 0.

## Test plan
- Reset then push `addi x1,x0,5` (0x00500093) at pc 0x40: next cycle `out_valid=1`, `out_imm=5`, `out_rd=1`, `load_regfile=1`, `out_illegal=0`.
- DEPTH=2, `out_ready=0`, push 3 instrs: third stalls (`in_ready=0`, occupancy=2). Raise `out_ready`: entries emerge in order; occupancy returns to 0.
- Full queue with push+pop same cycle: no push accepted; occupancy 2→1; tail not advanced.
- Push `beq` at pc 0x100 with offset -8 (0xFE000CE3): `out_imm=0xFFFFFFF8`, `branch_enable=1`, `cmpop=beq`. Push `sw` funct3=011: `out_illegal=1`, ctrl zero.
- Queue holding 2 entries + flush with a simultaneous push: next cycle occupancy=0, `out_valid=0`, pushed instruction never appears.
- `mul x3,x1,x2` (0x022081B3): with `M_EXT_DECODE_EN`, `m_enable=1` and `out_illegal=0`; without it, `out_illegal=1`. Also `addi x0,x0,0` gives `load_regfile=0`.
